conv1d_output_packer: RTL
=========================

Name: conv1d_output_packer

Overview:
- Downstream stage of the conv1d CFU datapath: takes the quantized int8 results produced per output pixel/channel and packs four of them into one 32-bit word.
- Buffers packed words in a small word FIFO so the CPU can drain four results per CFU response instead of one.
- Handles partial words at end of row (flush with padding) and back-pressures the producer when storage is exhausted.

Parameters:
- DEPTH, 16, number of 32-bit words in the FIFO; power of two, ≥2.
- PAD_BYTE, 8'h00, value written into unused byte lanes on flush.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  producer presents an int8 result.
- in_data  in  8  result byte (low 8 bits of quanted accumulator).
- in_ready  out  1  byte accepted on an edge where in_valid && in_ready.
- flush  in  1  single-cycle request to emit the current partial word.
- flush_busy  out  1  a flush is pending and not yet pushed.
- pop  in  1  consumer removes the head word; ignored when empty.
- out_data  out  32  FIFO head word (first-word-fall-through); 0 when empty.
- out_valid  out  1  FIFO non-empty.
- word_count  out  $clog2(DEPTH)+1  words currently stored.
- byte_idx  out  2  bytes held in the packing register (0..3).

Behaviour:
- Reset (async assert, sync-safe release): pack register = 0, byte_idx = 0, FIFO empty, word_count = 0, out_valid = 0, out_data = 0, flush_busy = 0, in_ready = 1. Reset mid-word discards partial bytes; no word is emitted.
- Packing: little-endian. The accepted byte goes to lane byte_idx (lane 0 = bits 7:0). byte_idx increments mod 4.
- Accepting the 4th byte (byte_idx == 3) pushes {in_data, lanes 2..0} into the FIFO on the same edge. byte_idx returns to 0.
- Push latency: the word is visible on out_data/out_valid the cycle after the accepting edge, provided the FIFO was empty.
- in_ready = !(byte_idx == 3 && fifo_full && !pop) && !flush_busy. Bytes for lanes 0..2 are accepted even when the FIFO is full; only a word-completing byte stalls.
- Flush, single-cycle pulse:
  - byte_idx == 0 and no byte accepted the same cycle: no-op.
  - A byte accepted on the flush cycle is included first.
  - The resulting partial word fills unused upper lanes with PAD_BYTE.
  - If a byte accepted on the flush cycle completes a word, that word is pushed and no extra word follows.
  - If the FIFO cannot take the partial word (full, no pop), flush_busy = 1 and in_ready = 0 until the push occurs.
  - Flush asserted while flush_busy is already set is ignored.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than log2(DEPTH) for full/empty detection.
  - Simultaneous push and pop is legal at every occupancy, including full (occupancy unchanged) and empty (pop ignored, push occurs).
  - Pop when empty is a no-op.
  - Pointers wrap modulo DEPTH.
- word_count is updated on the same edge as push/pop: +1 on push only, −1 on pop only, unchanged on both.
- No overflow or underflow is possible by construction. The bench asserts this.

Decomposition:
- Shared package conv1d_pkg:
  - BYTE_SIZE = 8, INT32_SIZE = 32, BYTES_PER_WORD = 4.
  - typedef logic [7:0] byte_t.
  - typedef logic [31:0] word_t.
- Sub-module word_fifo: parameterized DEPTH/WIDTH, FWFT, push/pop/full/empty/count, same async active-high rst.
- Top level holds the packing register, lane index and flush FSM. Flush FSM states:
  - IDLE → PENDING, when a flush needs a push and the FIFO is full.
  - PENDING → IDLE, on the push.

Test Plan:
- Bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles → out_valid rises the cycle after the 4th edge, out_data = 0x44332211, word_count = 1, byte_idx = 0.
- Bytes 0xAA, 0xBB, 0xCC, then flush → out_data = 0x00CCBBAA. A repeat flush with byte_idx = 0 adds no word.
- Fill 16 words, then bytes 0x01, 0x02, 0x03 accepted, 4th byte 0x04 sees in_ready = 0. Pop on the next cycle → 0x04 accepted that cycle, word_count stays 16, the last read-out word is 0x04030201.
- FIFO full, byte_idx = 2, flush → flush_busy = 1 and in_ready = 0. After one pop, the partial word 0x0000xxxx is pushed, flush_busy = 0, and word_count returns to 16.
- Byte 0x55 and flush in the same cycle with byte_idx = 3 and lanes 0x10, 0x20, 0x30 → a single word 0x55302010, no padded word.
- Assert rst after 2 bytes with 3 words queued → immediately out_valid = 0, word_count = 0, byte_idx = 0. The next 4 bytes form a clean word.

Source files
------------

// File: rtl/conv1d_pkg.sv
// Shared types and sizes for the conv1d CFU datapath.
package conv1d_pkg;

    localparam int unsigned BYTE_SIZE      = 8;
    localparam int unsigned INT32_SIZE     = 32;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef logic [BYTE_SIZE-1:0]  byte_t;
    typedef logic [INT32_SIZE-1:0] word_t;

    typedef enum logic {
        FLUSH_IDLE,
        FLUSH_PENDING
    } flush_state_e;

endpackage

// File: rtl/conv1d_output_packer_if.sv
// Producer/consumer bundle of the conv1d output packer.
interface conv1d_output_packer_if #(
    parameter int unsigned DEPTH = 16
);
    import conv1d_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    byte_t            in_data;
    logic             in_ready;
    logic             flush;
    logic             flush_busy;
    logic             pop;
    word_t            out_data;
    logic             out_valid;
    logic [CNT_W-1:0] word_count;
    logic [1:0]       byte_idx;

    modport master (
        output in_valid, in_data, flush, pop,
        input  in_ready, flush_busy, out_data, out_valid, word_count, byte_idx
    );

    modport slave (
        input  in_valid, in_data, flush, pop,
        output in_ready, flush_busy, out_data, out_valid, word_count, byte_idx
    );

endinterface

// File: rtl/word_fifo.sv
// First-word-fall-through circular word FIFO; push on full is taken only with a same-cycle pop.
module word_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rdata   = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage carries no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/conv1d_output_packer.sv
// Packs int8 results little-endian into 32-bit words and queues them for the CPU,
// with padded flush of partial words and a pending state when the FIFO is full.
module conv1d_output_packer
    import conv1d_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter byte_t       PAD_BYTE = 8'h00
) (
    input  logic                         clk,
    input  logic                         rst,
    conv1d_output_packer_if.slave        bus
);

    flush_state_e state_q, state_d;
    word_t        pack_q, pack_d;
    word_t        pend_q, pend_d;
    logic [1:0]   byte_idx_q, byte_idx_d;

    logic         in_ready_c;
    logic         accept;
    logic [2:0]   lanes_used;
    word_t        merged;
    word_t        padded;
    word_t        push_word;
    logic         push;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_room;

    assign in_ready_c = !(byte_idx_q == 2'd3 && fifo_full && !bus.pop) && (state_q != FLUSH_PENDING);
    assign accept     = bus.in_valid && in_ready_c;
    assign fifo_room  = !fifo_full || bus.pop;
    assign lanes_used = {1'b0, byte_idx_q} + 3'(accept);

    // Current lanes with this cycle's byte merged in, and its padded form for flush.
    always_comb begin
        merged = pack_q;
        if (accept) merged[{byte_idx_q, 3'b000} +: BYTE_SIZE] = bus.in_data;
        for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
            padded[i*BYTE_SIZE +: BYTE_SIZE] = (3'(i) < lanes_used) ? merged[i*BYTE_SIZE +: BYTE_SIZE]
                                                                   : PAD_BYTE;
        end
    end

    always_comb begin
        state_d    = state_q;
        pack_d     = pack_q;
        pend_d     = pend_q;
        byte_idx_d = byte_idx_q;
        push       = 1'b0;
        push_word  = merged;
        case (state_q)
            FLUSH_IDLE: begin
                if (accept) begin
                    pack_d     = merged;
                    byte_idx_d = byte_idx_q + 2'd1;
                end
                if (accept && byte_idx_q == 2'd3) begin
                    push   = 1'b1;
                    pack_d = '0;
                end else if (bus.flush && lanes_used != 3'd0) begin
                    pack_d     = '0;
                    byte_idx_d = 2'd0;
                    if (fifo_room) begin
                        push      = 1'b1;
                        push_word = padded;
                    end else begin
                        pend_d  = padded;
                        state_d = FLUSH_PENDING;
                    end
                end
            end
            FLUSH_PENDING: begin
                push_word = pend_q;
                if (fifo_room) begin
                    push    = 1'b1;
                    state_d = FLUSH_IDLE;
                end
            end
            default: state_d = FLUSH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FLUSH_IDLE;
            pack_q     <= '0;
            pend_q     <= '0;
            byte_idx_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            pack_q     <= pack_d;
            pend_q     <= pend_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INT32_SIZE)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_word),
        .pop   (bus.pop),
        .rdata (bus.out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (bus.word_count)
    );

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = !fifo_empty;
    assign bus.flush_busy = (state_q == FLUSH_PENDING);
    assign bus.byte_idx   = byte_idx_q;

endmodule
